// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if
//   Bundles the run/hold enable and every timing output of vga_timing_gen.
//   master : the timing generator (takes en, drives the timing signals)
//   slave  : the consumer (renderer / connector side), drives en
// Signals:
//   en          run (1) / hold (0)
//   p_tick      one-clk pulse per pixel period
//   hsync/vsync sync outputs, polarity set by the generator parameters
//   video_on    (x,y) inside the visible area
//   x, y        pixel coordinates, CW bits
//   line_start  pulse on the tick of pixel x=0
//   frame_start pulse on the tick of pixel (0,0)
//   frame_cnt   completed-frame count, FRAME_W bits
interface vga_timing_gen_if #(
  parameter int unsigned CW      = 10,
  parameter int unsigned FRAME_W = 16
);
  logic               en;
  logic               p_tick;
  logic               hsync;
  logic               vsync;
  logic               video_on;
  logic [CW-1:0]      x;
  logic [CW-1:0]      y;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output p_tick, hsync, vsync, video_on, x, y,
           line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  p_tick, hsync, vsync, video_on, x, y,
           line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA display timing generator. Divides the system clock by
//   CLK_DIV to form the pixel tick, walks x/y across the full raster
//   (active + porches + sync) and decodes hsync, vsync and video_on.
// Ports:
//   clk  system clock
//   rst  asynchronous, active-low reset
//   bus  vga_timing_gen_if.master : en in; p_tick, hsync, vsync, video_on,
//        x, y, line_start, frame_start, frame_cnt out
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  vga_timing_gen_if.master   bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CW-1:0] X_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_VIS      = CW'(V_ACTIVE);

  logic [PW-1:0]      presc_q;
  logic [CW-1:0]      x_q, y_q;
  logic [CW-1:0]      x_d, y_d;
  logic [FRAME_W-1:0] frame_q;
  logic               hs_q, vs_q, vid_q;
  logic               hs_d, vs_d, vid_d;
  logic               tick;
  logic               tick_out;
  logic               x_wrap, y_wrap;

  // tick drives the state update; with CLK_DIV=1 it equals en.
  always_comb begin
    tick   = bus.en && (presc_q == PRESC_LAST);
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
  end

  // Next-state coordinates and the sync/video decode of those coordinates,
  // so the registered decode lands on the same edge as x/y.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (tick) begin
      x_d = x_wrap ? '0 : x_q + CW'(1);
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + CW'(1);
      end
    end
    hs_d  = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d  = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    vid_d = (x_d < X_VIS) && (y_d < Y_VIS);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      vid_q   <= 1'b1;
    end else begin
      if (bus.en) begin
        presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        x_q   <= x_d;
        y_q   <= y_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        vid_q <= vid_d;
        if (x_wrap && y_wrap) begin
          frame_q <= frame_q + FRAME_W'(1);
        end
      end
    end
  end

  // Masking with rst keeps the visible tick low during reset even when
  // CLK_DIV=1, where the prescaler compare is always true.
  always_comb begin
    tick_out = tick && rst;
  end

  assign bus.p_tick      = tick_out;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.video_on    = vid_q;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.line_start  = tick_out && (x_q == '0);
  assign bus.frame_start = tick_out && (x_q == '0) && (y_q == '0);
  assign bus.frame_cnt   = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk;
  logic rst;

  int tests;
  int fails;

  // Enabled-clock counts since reset, one per instance.
  longint na, nb, nc;

  typedef struct {
    int x;
    int y;
    int fc;
    bit pt;
    bit hs;
    bit vs;
    bit vid;
    bit ls;
    bit fs;
  } exp_t;

  vga_timing_gen_if #(.CW(10), .FRAME_W(16)) bus_a ();
  vga_timing_gen_if #(.CW(4),  .FRAME_W(2))  bus_b ();
  vga_timing_gen_if #(.CW(5),  .FRAME_W(3))  bus_c ();

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .FRAME_W(16)
  ) u_a (.clk(clk), .rst(rst), .bus(bus_a));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FRAME_W(2)
  ) u_b (.clk(clk), .rst(rst), .bus(bus_b));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(5), .FRAME_W(3)
  ) u_c (.clk(clk), .rst(rst), .bus(bus_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      na <= 0;
      nb <= 0;
      nc <= 0;
    end else begin
      if (bus_a.en) na <= na + 1;
      if (bus_b.en) nb <= nb + 1;
      if (bus_c.en) nc <= nc + 1;
    end
  end

  // Expected outputs from the enabled-clock count: pixel index = n / div,
  // raster position and frame number follow by division/modulo.
  function automatic exp_t ref_out(longint n, bit en, bit rs, int d,
                                   int ha, int hfp, int hsw, int hbp,
                                   int va, int vfp, int vsw, int vbp,
                                   bit hp, bit vp, int fw);
    exp_t e;
    longint ticks, ht, vt;
    bit hs_act, vs_act;
    ht     = longint'(ha + hfp + hsw + hbp);
    vt     = longint'(va + vfp + vsw + vbp);
    ticks  = n / d;
    e.x    = int'(ticks % ht);
    e.y    = int'((ticks / ht) % vt);
    e.fc   = int'((ticks / (ht * vt)) % (longint'(1) << fw));
    e.pt   = rs && en && ((n % d) == longint'(d - 1));
    hs_act = (e.x >= ha + hfp) && (e.x < ha + hfp + hsw);
    vs_act = (e.y >= va + vfp) && (e.y < va + vfp + vsw);
    e.hs   = hs_act ? hp : !hp;
    e.vs   = vs_act ? vp : !vp;
    e.vid  = (e.x < ha) && (e.y < va);
    e.ls   = e.pt && (e.x == 0);
    e.fs   = e.pt && (e.x == 0) && (e.y == 0);
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_all(string id, exp_t e,
                         logic [31:0] x, logic [31:0] y, logic [31:0] fc,
                         logic [31:0] pt, logic [31:0] hs, logic [31:0] vs,
                         logic [31:0] vid, logic [31:0] ls, logic [31:0] fs);
    cmp({id, "_x"},           x,   e.x);
    cmp({id, "_y"},           y,   e.y);
    cmp({id, "_frame_cnt"},   fc,  e.fc);
    cmp({id, "_p_tick"},      pt,  32'(e.pt));
    cmp({id, "_hsync"},       hs,  32'(e.hs));
    cmp({id, "_vsync"},       vs,  32'(e.vs));
    cmp({id, "_video_on"},    vid, 32'(e.vid));
    cmp({id, "_line_start"},  ls,  32'(e.ls));
    cmp({id, "_frame_start"}, fs,  32'(e.fs));
  endtask

  task automatic check_a();
    exp_t e;
    e = ref_out(na, bus_a.en, rst, 4, 640, 16, 96, 48, 480, 10, 2, 33,
                1'b0, 1'b0, 16);
    cmp_all("a", e, 32'(bus_a.x), 32'(bus_a.y), 32'(bus_a.frame_cnt),
            32'(bus_a.p_tick), 32'(bus_a.hsync), 32'(bus_a.vsync),
            32'(bus_a.video_on), 32'(bus_a.line_start), 32'(bus_a.frame_start));
  endtask

  task automatic check_b();
    exp_t e;
    e = ref_out(nb, bus_b.en, rst, 1, 8, 1, 2, 1, 4, 1, 1, 1,
                1'b1, 1'b1, 2);
    cmp_all("b", e, 32'(bus_b.x), 32'(bus_b.y), 32'(bus_b.frame_cnt),
            32'(bus_b.p_tick), 32'(bus_b.hsync), 32'(bus_b.vsync),
            32'(bus_b.video_on), 32'(bus_b.line_start), 32'(bus_b.frame_start));
  endtask

  task automatic check_c();
    exp_t e;
    e = ref_out(nc, bus_c.en, rst, 3, 10, 2, 3, 2, 5, 1, 2, 1,
                1'b0, 1'b0, 3);
    cmp_all("c", e, 32'(bus_c.x), 32'(bus_c.y), 32'(bus_c.frame_cnt),
            32'(bus_c.p_tick), 32'(bus_c.hsync), 32'(bus_c.vsync),
            32'(bus_c.video_on), 32'(bus_c.line_start), 32'(bus_c.frame_start));
  endtask

  // One clock: sample on the falling edge, check all three instances,
  // then pick a new random enable for instance c.
  task automatic step();
    @(negedge clk);
    check_a();
    check_b();
    check_c();
    bus_c.en = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int cyc, last_ls, hs_fall, cnt, vs_hi;
    bit hs_prev, found, held;
    logic [1:0] fc0;

    tests    = 0;
    fails    = 0;
    rst      = 1'b0;
    bus_a.en = 1'b1;
    bus_b.en = 1'b1;
    bus_c.en = 1'b1;

    // Reset held low for 100 ns.
    repeat (9) @(negedge clk);
    step();
    cmp("rst_a_hsync", 32'(bus_a.hsync), 32'd1);
    cmp("rst_a_vsync", 32'(bus_a.vsync), 32'd1);
    cmp("rst_a_video_on", 32'(bus_a.video_on), 32'd1);
    cmp("rst_b_p_tick", 32'(bus_b.p_tick), 32'd0);
    rst = 1'b1;

    // First frame_start in the cycle ending at the 4th edge after release.
    for (int i = 1; i <= 3; i++) begin
      step();
      cmp("first_frame_start", 32'(bus_a.frame_start), 32'(i == 3));
    end

    // Line period and hsync placement over three lines.
    cyc     = 3;
    last_ls = 3;
    hs_fall = 0;
    hs_prev = 1'b1;
    repeat (9800) begin
      step();
      cyc++;
      if (bus_a.line_start) begin
        cmp("line_period", 32'(cyc - last_ls), 32'd3200);
        last_ls = cyc;
      end
      if (bus_a.hsync !== hs_prev) begin
        if (!bus_a.hsync) begin
          hs_fall = cyc;
          cmp("hsync_fall_x", 32'(bus_a.x), 32'd656);
        end else begin
          cmp("hsync_width", 32'(cyc - hs_fall), 32'd384);
        end
        hs_prev = bus_a.hsync;
      end
    end

    // Hold for 37 clocks at x=100 stretches the line by exactly 37 clocks.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      found = bus_a.line_start;
    end
    cmp("hold_sync_seen", 32'(found), 32'd1);
    cnt   = 0;
    held  = 1'b0;
    found = 1'b0;
    while (!found && cnt < 5000) begin
      step();
      cnt++;
      if (bus_a.line_start) begin
        found = 1'b1;
      end else if (!held && bus_a.x == 10'd100) begin
        bus_a.en = 1'b0;
        repeat (37) begin
          step();
          cnt++;
          cmp("hold_x", 32'(bus_a.x), 32'd100);
          cmp("hold_p_tick", 32'(bus_a.p_tick), 32'd0);
        end
        bus_a.en = 1'b1;
        held = 1'b1;
      end
    end
    cmp("hold_line_period", 32'(cnt), 32'd3237);

    // Random enable on instance a.
    repeat (3000) begin
      step();
      bus_a.en = ($urandom_range(0, 3) != 0);
    end
    bus_a.en = 1'b1;

    // Small raster: 84-clock frame, one 12-clock vsync line, 2-bit wrap.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      found = bus_b.frame_start;
    end
    cmp("b_frame_start_seen", 32'(found), 32'd1);
    fc0   = bus_b.frame_cnt;
    cnt   = 0;
    vs_hi = 0;
    do begin
      step();
      cnt++;
      if (bus_b.vsync) vs_hi++;
    end while (!bus_b.frame_start && cnt < 500);
    cmp("b_frame_period", 32'(cnt), 32'd84);
    cmp("b_vsync_width", 32'(vs_hi), 32'd12);
    repeat (3 * 84) step();
    cmp("b_frame_cnt_wrap", 32'(bus_b.frame_cnt), 32'(fc0));
    cmp("b_frame_start_wrap", 32'(bus_b.frame_start), 32'd1);
    repeat (600) begin
      step();
      bus_b.en = ($urandom_range(0, 1) != 0);
    end
    bus_b.en = 1'b1;

    // Asynchronous reset mid-line at x=300.
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      step();
      found = (bus_a.x == 10'd300);
    end
    cmp("mid_reset_x_seen", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1;
    cmp("async_rst_a_x", 32'(bus_a.x), 32'd0);
    cmp("async_rst_a_y", 32'(bus_a.y), 32'd0);
    cmp("async_rst_a_hsync", 32'(bus_a.hsync), 32'd1);
    cmp("async_rst_a_video_on", 32'(bus_a.video_on), 32'd1);
    cmp("async_rst_a_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
    cmp("async_rst_b_hsync", 32'(bus_b.hsync), 32'd0);
    cmp("async_rst_b_p_tick", 32'(bus_b.p_tick), 32'd0);
    repeat (4) step();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      cmp("restart_frame_start", 32'(bus_a.frame_start), 32'(i == 3));
    end
    repeat (500) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
